bus_mem_responder: RTL and testbench
====================================

# bus_mem_responder

Word-addressed 16-bit memory that answers the CPU's `en`/`rdwr`/`addr`/`dataout` bus and returns read data on `datain`; it is the responder end of the CPU memory interface. It also carries a byte-serial program loader, so a host can fill memory through 8 pins while the CPU is held off the bus. It sits between the CPU and the top-level pin mux.

## Interface
Parameters:
- `AW`, 5: memory address width; depth = 2^AW words of 16 bits.

Ports:
- `clkin`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  bus cycle request from CPU.
- `rdwr`  in  1  0 = read, 1 = write; valid when `en`=1.
- `addr`  in  12  CPU word address; only `addr[AW-1:0]` used, upper bits ignored (aliasing).
- `wdata`  in  16  CPU write data (CPU `dataout`).
- `rdata`  out  16  read data to CPU `datain`; registered.
- `ld_mode`  in  1  1 = loader owns memory, CPU port ignored.
- `ld_valid`  in  1  loader byte strobe.
- `ld_byte`  in  8  loader byte.
- `ld_ready`  out  1  loader can accept a byte this cycle.
- `ld_words`  out  AW+1  count of words written since `ld_mode` rose, saturating at 2^AW.
- `cpu_hold`  out  1  = `ld_mode` registered; top level ORs into CPU `rst`.

## Operation
- CPU read: at an edge with `en`=1, `rdwr`=0, `ld_mode`=0: `rdata` <= mem[addr[AW-1:0]]. `rdata` holds its value otherwise (including during writes and loader activity).
- CPU write: at an edge with `en`=1, `rdwr`=1, `ld_mode`=0: mem[addr[AW-1:0]] <= `wdata`. `rdata` unchanged.
- Read and write never coincide (single `rdwr`); write then read same address on next cycle returns the new word.
- Loader FSM states IDLE, LO, HI, WR:
  - IDLE: `ld_ready`=0. `ld_mode`=1 -> LO; pointer <= 0, `ld_words` <= 0.
  - LO: `ld_ready`=1. `ld_valid` -> latch `ld_byte` as bits [7:0], go HI.
  - HI: `ld_ready`=1. `ld_valid` -> latch `ld_byte` as bits [15:8], go WR.
  - WR: `ld_ready`=0; mem[pointer] <= assembled word; pointer <= pointer+1 (wraps mod 2^AW); `ld_words` increments, saturating at 2^AW; go LO.
  - Any state: `ld_mode`=0 -> IDLE next edge; a half-assembled word (in HI) is discarded, a word in WR is still written that edge.
- `ld_valid` while `ld_ready`=0 is ignored (byte dropped, no state change).
- While `ld_mode`=1, CPU `en` is ignored entirely (no read, no write, `rdata` frozen).
- Memory contents are not reset; reset affects only control state and outputs.

## Timing
- Reset values: `rdata`=0, `ld_ready`=0, `ld_words`=0, `cpu_hold`=0, FSM=IDLE, pointer=0, byte latch=0.
- Reset mid-load: FSM to IDLE immediately; any pending word not written; already-written words retained.
- Read latency: 1 cycle; `rdata` valid from the edge that sampled `en`, before the CPU samples `datain` one cycle later.
- Write: takes effect at the sampling edge; 0 wait states, no acknowledge.
- Loader throughput: 1 word per 3 cycles at best (LO, HI, WR). `ld_ready` is a combinational decode of FSM state only, so no combinational path from `ld_valid`.
- `cpu_hold` follows `ld_mode` by 1 cycle, asserted from the first loader cycle through one cycle after `ld_mode` falls.

## Test plan
- Reset: assert `rst` mid-cycle asynchronously -> `rdata`=0, `ld_ready`=0, `ld_words`=0, `cpu_hold`=0 immediately, without waiting for a clock edge.
- CPU write/read: write 16'hA5C3 to addr 12'h003, next cycle read 12'h003 -> `rdata`=16'hA5C3 one edge after read request; read addr 12'h023 (AW=5) -> same word (aliasing).
- Loader: `ld_mode`=1, bytes 34,12,78,56 -> mem[0]=16'h1234, mem[1]=16'h5678, `ld_words`=2; `ld_ready` low exactly during each WR cycle.
- Loader abort: send one byte 8'hEE then drop `ld_mode` -> FSM IDLE, `ld_words` unchanged, mem[pointer] unchanged.
- Bus lockout: `ld_mode`=1 with CPU `en`=1 `rdwr`=1 to addr 0 -> mem[0] keeps loader value; CPU read during `ld_mode` leaves `rdata` frozen.
- Wrap/saturate: load 33 words (AW=5) -> word 33 overwrites mem[0], `ld_words`=32.

Source files
------------

// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Word-addressed 2^AW x 16 memory answering the CPU en/rdwr/addr bus, with a
//   byte-serial program loader that owns the memory while ld_mode is high.
//
// Ports
//   clkin     system clock, rising edge
//   rst       asynchronous active-high reset (control state and outputs only;
//             memory contents are not reset)
//   en        CPU bus cycle request
//   rdwr      0 = read, 1 = write (valid with en)
//   addr      CPU word address, only addr[AW-1:0] decoded (upper bits alias)
//   wdata     CPU write data
//   rdata     registered read data, holds between reads
//   ld_mode   1 = loader owns memory, CPU port ignored
//   ld_valid  loader byte strobe, honoured only while ld_ready
//   ld_byte   loader byte (low byte first, then high byte)
//   ld_ready  loader can accept a byte this cycle (decoded from state only)
//   ld_words  words written since ld_mode rose, saturating at 2^AW
//   cpu_hold  ld_mode delayed one cycle, used to hold the CPU in reset
module bus_mem_responder #(
  parameter int unsigned AW = 5
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          en,
  input  logic          rdwr,
  input  logic [11:0]   addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  input  logic          ld_mode,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  output logic [AW:0]   ld_words,
  output logic          cpu_hold
);

  localparam int unsigned DEPTH     = 1 << AW;
  localparam logic [AW:0] WORDS_MAX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WR
  } ld_state_t;

  ld_state_t     state_q;
  ld_state_t     state_d;

  logic [AW-1:0] ptr_q;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;
  logic [15:0]   mem [DEPTH];

  logic          lo_en;
  logic          hi_en;
  logic          ld_wr;
  logic          ld_clr;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_a;

  // Upper address bits are intentionally not decoded.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^addr[11:AW];

  assign cpu_a  = addr[AW-1:0];
  assign cpu_rd = en & ~rdwr & ~ld_mode;
  assign cpu_wr = en &  rdwr & ~ld_mode;

  // Loader next-state and control decode.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    lo_en    = 1'b0;
    hi_en    = 1'b0;
    ld_wr    = 1'b0;
    ld_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_mode) begin
          state_d = S_LO;
          ld_clr  = 1'b1;
        end
      end
      S_LO: begin
        ld_ready = 1'b1;
        if (!ld_mode) begin
          state_d = S_IDLE;
        end else if (ld_valid) begin
          lo_en   = 1'b1;
          state_d = S_HI;
        end
      end
      S_HI: begin
        ld_ready = 1'b1;
        if (!ld_mode) begin
          state_d = S_IDLE;
        end else if (ld_valid) begin
          hi_en   = 1'b1;
          state_d = S_WR;
        end
      end
      S_WR: begin
        // The assembled word is committed even if ld_mode has just fallen.
        ld_wr   = 1'b1;
        state_d = ld_mode ? S_LO : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      ld_words <= '0;
      cpu_hold <= 1'b0;
      rdata    <= '0;
    end else begin
      cpu_hold <= ld_mode;
      if (lo_en) begin
        lo_q <= ld_byte;
      end
      if (hi_en) begin
        hi_q <= ld_byte;
      end
      if (ld_clr) begin
        ptr_q    <= '0;
        ld_words <= '0;
      end else if (ld_wr) begin
        ptr_q <= ptr_q + 1'b1;
        if (ld_words != WORDS_MAX) begin
          ld_words <= ld_words + 1'b1;
        end
      end
      if (cpu_rd) begin
        rdata <= mem[cpu_a];
      end
    end
  end

  // Memory array, not reset. A WR-state commit can share an edge with a CPU
  // write when ld_mode has just fallen, so both writes are honoured; on the
  // same address the loader word lands last.
  always_ff @(posedge clkin) begin
    if (cpu_wr) begin
      mem[cpu_a] <= wdata;
    end
    if (ld_wr) begin
      mem[ptr_q] <= {hi_q, lo_q};
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

  localparam int unsigned AW = 5;

  logic          clkin;
  logic          rst;
  logic          en;
  logic          rdwr;
  logic [11:0]   addr;
  logic [15:0]   wdata;
  logic [15:0]   rdata;
  logic          ld_mode;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_ready;
  logic [AW:0]   ld_words;
  logic          cpu_hold;

  bus_mem_responder #(.AW(AW)) dut (
    .clkin    (clkin),
    .rst      (rst),
    .en       (en),
    .rdwr     (rdwr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ld_mode  (ld_mode),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_ready (ld_ready),
    .ld_words (ld_words),
    .cpu_hold (cpu_hold)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_model [32];
  logic [4:0]  ptr_model;
  logic [15:0] exp_q [$];

  typedef struct {
    logic        en;
    logic        rdwr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pop_rdata(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=empty_scoreboard required=entry", name);
    end else begin
      chk(name, {16'h0, rdata}, {16'h0, exp_q.pop_front()});
    end
  endtask

  // One CPU bus cycle driven at a negedge; rdata checked at the next negedge.
  task automatic cpu_cycle(input logic en_i, input logic rdwr_i, input logic [11:0] a,
                           input logic [15:0] d, input logic [15:0] exp, input string name);
    en    = en_i;
    rdwr  = rdwr_i;
    addr  = a;
    wdata = d;
    exp_q.push_back(exp);
    @(negedge clkin);
    pop_rdata(name);
    en = 1'b0;
  endtask

  task automatic cpu_read(input logic [11:0] a, input string name);
    logic [4:0] idx;
    idx = a[4:0];
    cpu_cycle(1'b1, 1'b0, a, 16'h0, mem_model[idx], name);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!ld_ready && n < 10) begin
      @(negedge clkin);
      n++;
    end
    if (!ld_ready) chk("ld_ready_wait", {31'h0, ld_ready}, 32'h1);
    ld_valid = 1'b1;
    ld_byte  = b;
    @(negedge clkin);
    ld_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge after the WR edge (state LO).
  task automatic load_word(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    @(negedge clkin);
    mem_model[ptr_model] = w;
    ptr_model = ptr_model + 1'b1;
  endtask

  function automatic logic [15:0] wrap_word(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {kb + 8'h40, ~kb};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b1, 12'h003, 16'hA5C3, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 12'h003, 16'h0000, 16'hA5C3};
    vt[2] = '{1'b1, 1'b0, 12'h023, 16'h0000, 16'hA5C3};
    vt[3] = '{1'b1, 1'b1, 12'h01F, 16'hBEEF, 16'hA5C3};
    vt[4] = '{1'b1, 1'b0, 12'h01F, 16'h0000, 16'hBEEF};
    vt[5] = '{1'b1, 1'b1, 12'h003, 16'h0F0F, 16'hBEEF};
    vt[6] = '{1'b1, 1'b0, 12'hFE3, 16'h0000, 16'h0F0F};
    vt[7] = '{1'b1, 1'b0, 12'h03F, 16'h0000, 16'hBEEF};
    vt[8] = '{1'b0, 1'b0, 12'h003, 16'h0000, 16'hBEEF};

    rst = 1'b1; en = 1'b0; rdwr = 1'b0; addr = '0; wdata = '0;
    ld_mode = 1'b0; ld_valid = 1'b0; ld_byte = '0;
    ptr_model = '0;
    for (int i = 0; i < 32; i++) mem_model[i] = 16'hxxxx;

    #1;
    chk("rst_rdata",    {16'h0, rdata},     32'h0);
    chk("rst_ld_ready", {31'h0, ld_ready},  32'h0);
    chk("rst_ld_words", {26'h0, ld_words},  32'h0);
    chk("rst_cpu_hold", {31'h0, cpu_hold},  32'h0);
    @(negedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);

    // CPU bus vectors.
    for (int i = 0; i < 9; i++) begin
      if (vt[i].en && vt[i].rdwr) mem_model[vt[i].addr[4:0]] = vt[i].wdata;
      cpu_cycle(vt[i].en, vt[i].rdwr, vt[i].addr, vt[i].wdata, vt[i].exp_rdata,
                $sformatf("vec%0d", i));
    end

    // Loader: two words.
    ld_mode = 1'b1;
    @(negedge clkin);
    ptr_model = '0;
    chk("ld_hold_on",   {31'h0, cpu_hold}, 32'h1);
    chk("ld_ready_lo0", {31'h0, ld_ready}, 32'h1);
    chk("ld_words_0",   {26'h0, ld_words}, 32'h0);
    send_byte(8'h34);
    chk("ld_ready_hi0", {31'h0, ld_ready}, 32'h1);
    send_byte(8'h12);
    chk("ld_ready_wr0", {31'h0, ld_ready}, 32'h0);
    chk("ld_words_wr0", {26'h0, ld_words}, 32'h0);
    @(negedge clkin);
    mem_model[0] = 16'h1234; ptr_model = 5'd1;
    chk("ld_ready_lo1", {31'h0, ld_ready}, 32'h1);
    chk("ld_words_1",   {26'h0, ld_words}, 32'h1);
    send_byte(8'h78);
    send_byte(8'h56);
    chk("ld_ready_wr1", {31'h0, ld_ready}, 32'h0);
    @(negedge clkin);
    mem_model[1] = 16'h5678; ptr_model = 5'd2;
    chk("ld_words_2",   {26'h0, ld_words}, 32'h2);
    ld_mode = 1'b0;
    #1;
    chk("hold_lag",     {31'h0, cpu_hold}, 32'h1);
    @(negedge clkin);
    chk("hold_off",     {31'h0, cpu_hold}, 32'h0);
    chk("idle_ready",   {31'h0, ld_ready}, 32'h0);
    chk("ld_words_kept",{26'h0, ld_words}, 32'h2);
    cpu_read(12'h000, "rd_ld0");
    cpu_read(12'h001, "rd_ld1");
    cpu_read(12'h021, "rd_ld1_alias");

    // Abort with a half-assembled word.
    ld_mode = 1'b1;
    @(negedge clkin);
    ptr_model = '0;
    send_byte(8'hEE);
    ld_mode = 1'b0;
    @(negedge clkin);
    chk("abort_ready",  {31'h0, ld_ready}, 32'h0);
    chk("abort_words",  {26'h0, ld_words}, 32'h0);
    cpu_read(12'h000, "abort_mem0");

    // ld_mode falls during WR: that word is still written.
    ld_mode = 1'b1;
    @(negedge clkin);
    ptr_model = '0;
    send_byte(8'hCD);
    send_byte(8'hAB);
    ld_mode = 1'b0;
    @(negedge clkin);
    mem_model[0] = 16'hABCD;
    chk("wrdrop_words", {26'h0, ld_words}, 32'h1);
    chk("wrdrop_ready", {31'h0, ld_ready}, 32'h0);
    cpu_read(12'h000, "wrdrop_mem0");
    cpu_read(12'h001, "wrdrop_mem1");

    // Bus lockout while loader owns memory.
    ld_mode = 1'b1;
    en = 1'b1; rdwr = 1'b1; addr = 12'h000; wdata = 16'hDEAD;
    @(negedge clkin);
    chk("lock_wr_rdata", {16'h0, rdata}, 32'h5678);
    rdwr = 1'b0; addr = 12'h003;
    @(negedge clkin);
    chk("lock_rd_rdata", {16'h0, rdata}, 32'h5678);
    en = 1'b0;
    ld_mode = 1'b0;
    @(negedge clkin);
    cpu_read(12'h000, "lock_mem0");

    // Wrap and saturate: 33 words into a 32-word memory.
    ld_mode = 1'b1;
    @(negedge clkin);
    ptr_model = '0;
    for (int k = 0; k < 33; k++) begin
      load_word(wrap_word(k));
      if (k == 31) chk("words_full", {26'h0, ld_words}, 32'd32);
    end
    chk("words_sat", {26'h0, ld_words}, 32'd32);
    ld_mode = 1'b0;
    @(negedge clkin);
    cpu_read(12'h000, "wrap_mem0");
    cpu_read(12'h001, "wrap_mem1");
    cpu_read(12'h01F, "wrap_mem31");

    // Asynchronous reset in the middle of a load.
    ld_mode = 1'b1;
    @(negedge clkin);
    ptr_model = '0;
    load_word(16'h7E81);
    send_byte(8'h99);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rdata",    {16'h0, rdata},    32'h0);
    chk("arst_ld_ready", {31'h0, ld_ready}, 32'h0);
    chk("arst_ld_words", {26'h0, ld_words}, 32'h0);
    chk("arst_cpu_hold", {31'h0, cpu_hold}, 32'h0);
    ld_mode = 1'b0;
    @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);
    chk("post_rst_ready", {31'h0, ld_ready}, 32'h0);
    cpu_read(12'h000, "arst_mem0");
    cpu_read(12'h001, "arst_mem1");

    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
